pc_gen_unit: RTL and testbench
==============================

Name: pc_gen_unit

Overview:
- Parametrised program-counter generator and next-generation successor of the single-register PC.
- Adds prioritised redirect sources (trap, branch, jump), an N-input stall vector, and a req/gnt fetch handshake with a buffered redirect.
- Sits between the branch/trap logic and the instruction memory/cache front end; its outputs feed IF.

Parameters:
XLEN, 32, PC and target width in bits
RESET_VEC, 32'h0000_0000, PC value loaded on reset
INST_BYTES, 4, sequential increment; power of two, 2 or 4
N_STALL, 2, number of stall request inputs (hazard, cache miss, ...)

Ports:
clk  in  1  clock; all state changes on posedge
rst  in  1  reset, asynchronous, active-low; asserted when 0
stall  in  N_STALL  any bit set = pipeline hold request
trap_valid  in  1  trap/exception redirect
trap_target  in  XLEN  trap handler address
br_valid  in  1  branch-taken redirect from EX
br_target  in  XLEN  branch target
jmp_valid  in  1  jump redirect from ID
jmp_target  in  XLEN  jump target
fetch_gnt  in  1  instruction memory accepted the request this cycle
fetch_req  out  1  fetch request; pc is the request address
inst_ce  out  1  instruction memory enable; equals fetch_req
pc  out  XLEN  current fetch address
misalign  out  1  one-cycle pulse: a redirect target was misaligned

Behaviour:
- Reset (rst=0, async): pc=RESET_VEC, state=BOOT, pend_v=0, pend_addr=0, misalign=0. Outputs fetch_req=0 and inst_ce=0.
- Reset mid-operation: identical. Any outstanding request is abandoned and no grant is expected afterwards.
- States:
  - BOOT: fetch_req=0. Next cycle go to RUN unconditionally. No fetch is issued in the first cycle after release.
  - RUN: fetch_req = ~|stall.
  - WAIT: fetch_req=1 regardless of stall. The request must stay stable until granted.
- fire = fetch_req & fetch_gnt.
- Redirect select, highest priority first: trap > br > jmp > pend > pc+INST_BYTES. new_redir = trap_valid|br_valid|jmp_valid.
- Target alignment: the low log2(INST_BYTES) bits of the selected redirect target are forced to 0. misalign=1 for the next cycle if any were set. A pending address is stored already aligned.
- Increment wraps modulo 2^XLEN: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- RUN, fire: pc <= selected next. pend_v <= 0. Stay in RUN.
- RUN, fetch_req=1 and no gnt: go to WAIT. pc is held. A new_redir that cycle is latched into pend_addr and sets pend_v=1.
- RUN, stall active (fetch_req=0):
  - If new_redir or pend_v: pc <= redirect/pend target and pend_v <= 0.
  - Otherwise pc is held.
  - No increment occurs.
- WAIT, no gnt: pc is held.
  - new_redir overwrites pend_addr using the same priority, and pend_v=1.
  - A later redirect replaces an earlier pending one, because the youngest redirect is architecturally correct.
- WAIT, gnt: pc <= selected next, where same-cycle redirects beat pend. pend_v <= 0. Go to RUN.
- Latency: one cycle from redirect/fire to the new pc on the output. A buffered redirect is applied on the granting edge.
- Simultaneous trap+br+jmp: only the trap is used; the others are dropped.
- stall bits are ORed; individual bits are not distinguished.

Test Plan:
- Reset release, stall=0, gnt=1 always: pc=0 with fetch_req=0 for one cycle, then pc = 0, 4, 8, 12 on successive cycles.
- Wrap: redirect to 32'hFFFF_FFF8 with gnt=1 -> pc FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- stall=2'b10 for 3 cycles at pc=0x20 -> fetch_req=0 and pc=0x20 held. Release stall -> 0x24 follows the next fire.
- gnt=0 for 3 cycles at pc=0x40, br_valid=1 target 0x100 in cycle 1, jmp_valid=1 target 0x200 in cycle 2 -> fetch_req=1, pc=0x40 held. On gnt, pc=0x200.
- Same cycle trap_valid (0x80), br_valid (0x100), jmp_valid (0x200) with fire -> pc=0x80. Br target 0x102 -> pc=0x100 and misalign pulses once.
- rst=0 asserted asynchronously mid-WAIT with pend_v=1 -> pc=RESET_VEC and fetch_req=0 immediately. Pend is cleared, and after release the sequence restarts from BOOT.

Source files
------------

// File: rtl/pc_gen_unit.sv
// Program-counter generator: prioritised trap/branch/jump redirect, stall vector,
// and a req/gnt fetch handshake that buffers the youngest redirect while waiting.
module pc_gen_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = '0,
    parameter int unsigned     INST_BYTES = 4,
    parameter int unsigned     N_STALL    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_STALL-1:0] stall,
    input  logic               trap_valid,
    input  logic [XLEN-1:0]    trap_target,
    input  logic               br_valid,
    input  logic [XLEN-1:0]    br_target,
    input  logic               jmp_valid,
    input  logic [XLEN-1:0]    jmp_target,
    input  logic               fetch_gnt,
    output logic               fetch_req,
    output logic               inst_ce,
    output logic [XLEN-1:0]    pc,
    output logic               misalign
);

    // state | meaning
    // BOOT  | first cycle after reset release, no fetch issued
    // RUN   | request whenever no stall bit is set
    // WAIT  | request outstanding, held stable until granted
    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_WAIT} state_t;

    localparam logic [XLEN-1:0] INC        = XLEN'(INST_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(INC - XLEN'(1));

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pend_v_q, pend_v_d;
    logic [XLEN-1:0] pend_addr_q, pend_addr_d;
    logic            misalign_q, misalign_d;

    logic            new_redir;
    logic [XLEN-1:0] redir_raw;
    logic [XLEN-1:0] redir_addr;
    logic [XLEN-1:0] next_addr;
    logic            fetch_req_c;

    assign new_redir = trap_valid | br_valid | jmp_valid;

    always_comb begin
        redir_raw = jmp_target;
        if (trap_valid) begin
            redir_raw = trap_target;
        end else if (br_valid) begin
            redir_raw = br_target;
        end
    end

    assign redir_addr = redir_raw & ALIGN_MASK;

    // Same-cycle redirects are younger than anything buffered, so they win over pend.
    always_comb begin
        next_addr = pc_q + INC;
        if (new_redir) begin
            next_addr = redir_addr;
        end else if (pend_v_q) begin
            next_addr = pend_addr_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;
        misalign_d  = new_redir & (|(redir_raw & ~ALIGN_MASK));
        fetch_req_c = 1'b0;
        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                if (new_redir) begin
                    pc_d = redir_addr;
                end
            end
            ST_RUN: begin
                fetch_req_c = ~(|stall);
                if (fetch_req_c) begin
                    if (fetch_gnt) begin
                        pc_d     = next_addr;
                        pend_v_d = 1'b0;
                    end else begin
                        state_d = ST_WAIT;
                        if (new_redir) begin
                            pend_addr_d = redir_addr;
                            pend_v_d    = 1'b1;
                        end
                    end
                end else if (new_redir || pend_v_q) begin
                    pc_d     = next_addr;
                    pend_v_d = 1'b0;
                end
            end
            ST_WAIT: begin
                fetch_req_c = 1'b1;
                if (fetch_gnt) begin
                    pc_d     = next_addr;
                    pend_v_d = 1'b0;
                    state_d  = ST_RUN;
                end else if (new_redir) begin
                    pend_addr_d = redir_addr;
                    pend_v_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_VEC;
            pend_v_q    <= 1'b0;
            pend_addr_q <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
            misalign_q  <= misalign_d;
        end
    end

    assign fetch_req = fetch_req_c;
    assign inst_ce   = fetch_req_c;
    assign pc        = pc_q;
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Bench for pc_gen_unit: a cycle model pushes expected pc/misalign into a queue
// at drive time; they are popped and compared after the clock edge.
module tb_pc_gen_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  stall = '0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_target = '0;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = '0;
    logic        jmp_valid = 1'b0;
    logic [31:0] jmp_target = '0;
    logic        fetch_gnt = 1'b0;
    logic        fetch_req;
    logic        inst_ce;
    logic [31:0] pc;
    logic        misalign;

    always #5 clk = ~clk;

    pc_gen_unit #(
        .XLEN(32), .RESET_VEC(32'h0000_0000), .INST_BYTES(4), .N_STALL(2)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .trap_valid(trap_valid), .trap_target(trap_target),
        .br_valid(br_valid), .br_target(br_target),
        .jmp_valid(jmp_valid), .jmp_target(jmp_target),
        .fetch_gnt(fetch_gnt), .fetch_req(fetch_req), .inst_ce(inst_ce),
        .pc(pc), .misalign(misalign)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        mis;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk = 0;
    int          n_err = 0;

    // model state: 0 boot, 1 run, 2 wait
    int          m_state;
    logic [31:0] m_pc;
    logic [31:0] m_pa;
    logic        m_pv;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pc    = 32'h0;
        m_pa    = 32'h0;
        m_pv    = 1'b0;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic [1:0] st,
                        input logic tv, input logic [31:0] tt,
                        input logic bv, input logic [31:0] bt,
                        input logic jv, input logic [31:0] jt,
                        input logic g);
        logic        req, nr, take;
        logic [31:0] tgt;
        exp_t        e;
        stall = st; trap_valid = tv; trap_target = tt;
        br_valid = bv; br_target = bt; jmp_valid = jv; jmp_target = jt;
        fetch_gnt = g;
        #1;
        req = (m_state == 1 && st == 2'b00) || m_state == 2;
        chk("fetch_req", {31'b0, fetch_req}, {31'b0, req});
        chk("inst_ce", {31'b0, inst_ce}, {31'b0, req});

        nr  = tv | bv | jv;
        tgt = tv ? tt : (bv ? bt : jt);
        e.mis = nr && (tgt[1:0] != 2'b00);
        tgt = tgt & 32'hFFFF_FFFC;
        take = (m_state == 0 && nr) || (req && g) || (m_state == 1 && !req && (nr || m_pv));
        if (take) begin
            m_pc = nr ? tgt : (m_pv ? m_pa : m_pc + 32'd4);
            m_pv = 1'b0;
        end else if (req && nr) begin
            m_pa = tgt;
            m_pv = 1'b1;
        end
        if (m_state == 0) m_state = 1;
        else if (m_state == 1 && req && !g) m_state = 2;
        else if (m_state == 2 && g) m_state = 1;
        e.pc = m_pc;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("pc", pc, e.pc);
            chk("misalign", {31'b0, misalign}, {31'b0, e.mis});
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [1:0] st, input logic g);
        step(st, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, g);
    endtask

    task automatic jump(input logic [31:0] t, input logic g);
        step(2'b00, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, t, g);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", {31'b0, fetch_req}, 32'h0);
        chk("rst_mis", {31'b0, misalign}, 32'h0);
        rst = 1'b1;

        // boot then sequential fetch
        for (int i = 0; i < 4; i++) idle(2'b00, 1'b1);
        chk("seq_pc", pc, 32'h0000_000C);

        // wrap
        jump(32'hFFFF_FFF8, 1'b1);
        for (int i = 0; i < 3; i++) idle(2'b00, 1'b1);
        chk("wrap_pc", pc, 32'h0000_0004);

        // stall hold
        jump(32'h0000_0020, 1'b1);
        for (int i = 0; i < 3; i++) idle(2'b10, 1'b1);
        chk("stall_pc", pc, 32'h0000_0020);
        idle(2'b00, 1'b1);
        chk("stall_rel", pc, 32'h0000_0024);
        idle(2'b01, 1'b1);
        chk("stall_b0", pc, 32'h0000_0024);

        // no grant with buffered redirects, youngest wins
        jump(32'h0000_0040, 1'b1);
        step(2'b00, 1'b0, 32'h0, 1'b1, 32'h0000_0100, 1'b0, 32'h0, 1'b0);
        step(2'b11, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0200, 1'b0);
        idle(2'b00, 1'b0);
        chk("wait_pc", pc, 32'h0000_0040);
        idle(2'b11, 1'b1);
        chk("pend_pc", pc, 32'h0000_0200);

        // priority and misalignment
        step(2'b00, 1'b1, 32'h0000_0080, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200, 1'b1);
        chk("prio_pc", pc, 32'h0000_0080);
        step(2'b00, 1'b0, 32'h0, 1'b1, 32'h0000_0102, 1'b0, 32'h0, 1'b1);
        chk("mis_pc", pc, 32'h0000_0100);
        chk("mis_pulse", {31'b0, misalign}, 32'h1);
        idle(2'b00, 1'b1);
        chk("mis_clear", {31'b0, misalign}, 32'h0);

        // async reset in WAIT with a pending redirect
        step(2'b00, 1'b0, 32'h0, 1'b1, 32'h0000_0300, 1'b0, 32'h0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_pc", pc, 32'h0);
        chk("arst_req", {31'b0, fetch_req}, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) idle(2'b00, 1'b1);
        chk("restart_pc", pc, 32'h0000_0008);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
